// File: rtl/jk_flag_arbiter.sv
// Round-robin arbiter granting four requesters single JK operations on a shared
// 8-bit flag register; a two-state FSM sequences IDLE (arbitrate/clear) and APPLY (commit).
module jk_flag_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned N_FLAGS = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N_REQ-1:0]                    req,
  input  logic [N_REQ-1:0]                    op_j,
  input  logic [N_REQ-1:0]                    op_k,
  input  logic [$clog2(N_FLAGS)*N_REQ-1:0]    addr,
  input  logic                                clr_all,
  output logic [N_REQ-1:0]                    grant,
  output logic                                done,
  output logic                                busy,
  output logic [N_FLAGS-1:0]                  flags
);

  localparam int unsigned AW = $clog2(N_FLAGS);
  localparam int unsigned PW = $clog2(N_REQ);

  typedef enum logic {IDLE, APPLY} state_t;

  state_t               state, state_n;
  logic [PW-1:0]        ptr, ptr_n;
  logic [PW-1:0]        win, win_n;
  logic [N_REQ-1:0]     grant_n;
  logic                 done_n;
  logic [N_FLAGS-1:0]   flags_n;
  logic                 lat_j, lat_j_n;
  logic                 lat_k, lat_k_n;
  logic [AW-1:0]        lat_a, lat_a_n;
  logic                 found;
  int unsigned          idx;

  assign busy = (state == APPLY);

  // Next-state: clr_all outranks requests in IDLE; APPLY commits the latched op.
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    win_n   = win;
    grant_n = '0;
    done_n  = 1'b0;
    flags_n = flags;
    lat_j_n = lat_j;
    lat_k_n = lat_k;
    lat_a_n = lat_a;
    found   = 1'b0;
    idx     = 0;
    case (state)
      IDLE: begin
        if (clr_all) begin
          flags_n = '0;
          done_n  = 1'b1;
        end else begin
          // Search from ptr upward with wraparound; first hit wins.
          for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
              found   = 1'b1;
              win_n   = PW'(idx);
              grant_n = N_REQ'(1) << idx;
              lat_j_n = op_j[idx];
              lat_k_n = op_k[idx];
              lat_a_n = addr[idx*AW +: AW];
              state_n = APPLY;
            end
          end
        end
      end
      APPLY: begin
        if (lat_j)      flags_n[lat_a] = 1'b1;
        else if (lat_k) flags_n[lat_a] = 1'b0;
        done_n  = 1'b1;
        ptr_n   = PW'(win + PW'(1));
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= '0;
      win   <= '0;
      grant <= '0;
      done  <= 1'b0;
      flags <= '0;
      lat_j <= 1'b0;
      lat_k <= 1'b0;
      lat_a <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      win   <= win_n;
      grant <= grant_n;
      done  <= done_n;
      flags <= flags_n;
      lat_j <= lat_j_n;
      lat_k <= lat_k_n;
      lat_a <= lat_a_n;
    end
  end

endmodule

// File: tb/tb_jk_flag_arbiter.sv
// Scoreboard bench for jk_flag_arbiter: stimulus queues expected grants and
// post-commit flag values; a negedge monitor pops them as grant/done appear.
module tb_jk_flag_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  op_j;
  logic [3:0]  op_k;
  logic [11:0] addr;
  logic        clr_all;
  logic [3:0]  grant;
  logic        done;
  logic        busy;
  logic [7:0]  flags;

  logic [3:0]  q_grant[$];
  logic [7:0]  q_flags[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  jk_flag_arbiter #(.N_REQ(4), .N_FLAGS(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .op_j   (op_j),
    .op_k   (op_k),
    .addr   (addr),
    .clr_all(clr_all),
    .grant  (grant),
    .done   (done),
    .busy   (busy),
    .flags  (flags)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One requester, single operation; req dropped once done has been seen.
  task automatic do_op(input int r, input logic j, input logic k,
                       input logic [2:0] a, input logic [7:0] ef);
    req[r]          = 1'b1;
    op_j[r]         = j;
    op_k[r]         = k;
    addr[3*r +: 3]  = a;
    q_grant.push_back(4'(1 << r));
    q_flags.push_back(ef);
    step();
    step();
    req  = '0;
    op_j = '0;
    op_k = '0;
  endtask

  // Monitor: each visible grant/done consumes one scoreboard entry.
  always @(negedge clk) begin
    if (grant !== 4'b0 || busy) begin
      check("busy_matches_grant", 32'(busy), 32'(grant != 4'b0));
      check("grant_onehot", 32'($countones(grant)), 32'd1);
      if (q_grant.size() == 0) check("grant_unexpected", 32'(grant), 32'h0);
      else                     check("grant", 32'(grant), 32'(q_grant.pop_front()));
    end
    if (done) begin
      if (q_flags.size() == 0) check("done_unexpected", 32'(done), 32'h0);
      else                     check("flags_at_done", 32'(flags), 32'(q_flags.pop_front()));
    end
  end

  initial begin
    logic [7:0] acc;
    reset = 1'b1; req = '0; op_j = '0; op_k = '0; addr = '0; clr_all = 1'b0;
    step(); step();
    reset = 1'b0;
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_done",  32'(done),  32'h0);
    check("reset_busy",  32'(busy),  32'h0);
    check("reset_flags", 32'(flags), 32'h0);

    // Basic op: J on flag 5.
    do_op(0, 1'b1, 1'b0, 3'd5, 8'h20);
    check("basic_flags", 32'(flags), 32'h20);

    // ptr now 1: all requesting starts at requester 1.
    req = 4'b1111;
    q_grant.push_back(4'b0010); q_grant.push_back(4'b0100); q_grant.push_back(4'b1000);
    q_grant.push_back(4'b0001); q_grant.push_back(4'b0010);
    repeat (5) q_flags.push_back(8'h20);
    repeat (10) step();
    req = '0;

    // After reset, ptr 0: full rotation with wrap 3 -> 0.
    reset = 1'b1; step(); reset = 1'b0;
    check("reset2_flags", 32'(flags), 32'h0);
    req = 4'b1111;
    q_grant.push_back(4'b0001); q_grant.push_back(4'b0010); q_grant.push_back(4'b0100);
    q_grant.push_back(4'b1000); q_grant.push_back(4'b0001);
    repeat (5) q_flags.push_back(8'h00);
    repeat (10) step();
    req = '0;
    repeat (3) step();
    check("idle_hold_flags", 32'(flags), 32'h0);

    // Set every flag via J ops from rotating requesters.
    acc = 8'h00;
    for (int i = 0; i < 8; i++) begin
      acc = acc | 8'(1 << i);
      do_op(i % 4, 1'b1, 1'b0, 3'(i), acc);
    end
    check("all_set", 32'(flags), 32'hFF);

    // K clears, J=K=1 sets, J=K=0 holds.
    do_op(2, 1'b0, 1'b1, 3'd0, 8'hFE);
    do_op(2, 1'b1, 1'b1, 3'd0, 8'hFF);
    do_op(2, 1'b0, 1'b0, 3'd0, 8'hFF);

    // Shape flags to 3C.
    do_op(0, 1'b0, 1'b1, 3'd0, 8'hFE);
    do_op(1, 1'b0, 1'b1, 3'd1, 8'hFC);
    do_op(3, 1'b0, 1'b1, 3'd6, 8'hBC);
    do_op(0, 1'b0, 1'b1, 3'd7, 8'h3C);
    check("pre_clear_flags", 32'(flags), 32'h3C);

    // clr_all beats req in the same IDLE cycle; req granted next edge.
    clr_all = 1'b1;
    req     = 4'b0100;
    q_flags.push_back(8'h00);
    step();
    clr_all = 1'b0;
    check("clr_grant", 32'(grant), 32'h0);
    check("clr_busy",  32'(busy),  32'h0);
    check("clr_flags", 32'(flags), 32'h0);
    q_grant.push_back(4'b0100);
    q_flags.push_back(8'h00);
    step();
    step();
    req = '0;

    // Reset during APPLY aborts the op with no done pulse.
    req[0] = 1'b1; op_j[0] = 1'b1; addr[2:0] = 3'd7;
    q_grant.push_back(4'b0001);
    step();
    check("abort_busy_before", 32'(busy), 32'h1);
    reset = 1'b1; req = '0; op_j = '0;
    step();
    reset = 1'b0;
    check("abort_flags", 32'(flags), 32'h0);
    check("abort_busy",  32'(busy),  32'h0);
    check("abort_done",  32'(done),  32'h0);
    repeat (2) step();

    // Inputs changed after the grant edge (incl. clr_all in APPLY) are ignored.
    req[1] = 1'b1; op_j[1] = 1'b1; addr[5:3] = 3'd3;
    q_grant.push_back(4'b0010);
    q_flags.push_back(8'h08);
    step();
    addr[5:3] = 3'd6; op_j = '0; op_k[1] = 1'b1; clr_all = 1'b1;
    step();
    clr_all = 1'b0; req = '0; op_k = '0;
    check("late_change_flags", 32'(flags), 32'h08);
    repeat (3) step();

    check("grant_queue_drained", 32'(q_grant.size()), 32'h0);
    check("flags_queue_drained", 32'(q_flags.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/jk_flag_arbiter.md
JK_FLAG_ARBITER -- requirements
Module: jk_flag_arbiter

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  N_REQ, 4, number of requesters (fixed at 4 for this revision)
  N_FLAGS, 8, number of shared JK flag bits (fixed at 8)
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk, in, 1, single system clock, rising edge
  reset, in, 1, synchronous, active-high reset
  req, in, 4, req[i] high = requester i wants one flag operation
  op_j, in, 4, J bit of requester i's operation
  op_k, in, 4, K bit of requester i's operation
  addr, in, 12, flag index of requester i in addr[3i+2:3i]
  clr_all, in, 1, request to clear every flag
  grant, out, 4, one-hot grant, high during a requester's APPLY cycle
  done, out, 1, one-cycle pulse, operation committed
  busy, out, 1, high while state is APPLY
  flags, out, 8, shared flag register
REQ-003 The block SHALL use one clock only; reset SHALL be synchronous and active-high.

Function
REQ-004 The FSM SHALL have exactly two states, IDLE and APPLY; busy = (state == APPLY).
REQ-005 In IDLE with clr_all=1, the next edge SHALL set flags=8'h00 and pulse done, stay in IDLE, and leave the pointer and grant=0 unchanged; clr_all SHALL beat all req.
REQ-006 In IDLE with clr_all=0 and req!=0, the next edge SHALL select winner w, the first i with req[i]=1 searching ptr, ptr+1, ... mod 4.
REQ-007 On that same edge the block SHALL set grant=onehot(w), latch op_j[w], op_k[w] and addr[w], and go to APPLY.
REQ-008 In IDLE with req=0 and clr_all=0, all state SHALL hold; grant=0; done=0.
REQ-009 In APPLY, the next edge SHALL update flags[a] from the latched J/K (a = latched address):
  J=1: set to 1 (J wins over K, so J=K=1 also sets)
  J=0, K=1: clear to 0
  J=0, K=0: hold
  No other flag bit SHALL change.
REQ-010 On that same edge the block SHALL pulse done=1 for one cycle, set grant=0, set ptr=(w+1) mod 4, and return to IDLE.
REQ-011 clr_all, req and op inputs asserted during APPLY SHALL be ignored for that cycle; clr_all SHALL be sampled only in IDLE.
REQ-012 Latency SHALL be as follows: req sampled at edge n gives grant high after edge n, flag update and done high after edge n+1, and the earliest next grant after edge n+2.
REQ-013 A requester SHALL drop req in the cycle done is seen high. A req still high in IDLE SHALL be re-arbitrated at its new round-robin priority; no requester SHALL wait more than 3 other grants.
REQ-014 ptr SHALL wrap from 3 to 0; grant SHALL never have more than one bit set.
REQ-015 Changes on op_j, op_k and addr after the grant edge SHALL NOT affect the committed operation.

Reset
REQ-016 With reset=1 at an edge, the block SHALL set state=IDLE, ptr=0, grant=0, done=0 and flags=8'h00. Reset SHALL win over every other input.
REQ-017 Reset asserted during APPLY SHALL abort the pending operation with no flag change and no done pulse.

Verification
REQ-018 Reset, then req=4'b0001, op_j[0]=1, addr[2:0]=5 -> grant=0001 for one cycle, then flags=8'h20, done pulses once, ptr=1.
REQ-019 All four req held high continuously -> grants in order 0001, 0010, 0100, 1000, 0001, with a grant every 2 cycles.
REQ-020 flags=8'hFF; requester 2 with J=0, K=1, addr=0, then a second op with J=1, K=1, addr=0 -> flags=8'hFE, then 8'hFF. A third op with J=K=0 -> flags unchanged.
REQ-021 clr_all=1 and req=4'b0100 in the same IDLE cycle with flags=8'h3C -> flags=8'h00, done pulse, grant=0. Then requester 2 is granted on the following edge.
REQ-022 Reset asserted in an APPLY cycle with granted op J=1, addr=7 -> flags=8'h00, state=IDLE, no done pulse.
REQ-023 addr[w] changed from 3 to 6 on the cycle after the grant -> only flags[3] changes.
